// File: rtl/johnson_step_sequencer.sv
// Command-driven controller for a 2*WIDTH-state Johnson ring.
// Accepts step/home commands over valid/ready. It advances the ring one step
// every period+1 clocks and pulses done (qualified by aborted) on completion.
module johnson_step_sequencer #(
    parameter int WIDTH    = 4,
    parameter int STEPS_W  = 8,
    parameter int PERIOD_W = 8
) (
    input  logic                           clk,
    input  logic                           sync_reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_dir,
    input  logic                           cmd_home,
    input  logic [STEPS_W-1:0]             cmd_steps,
    input  logic [PERIOD_W-1:0]            cmd_period,
    input  logic                           abort,
    output logic [WIDTH-1:0]               out,
    output logic [$clog2(2*WIDTH)-1:0]     phase,
    output logic                           busy,
    output logic                           done,
    output logic                           aborted
);
    localparam int PW = $clog2(2*WIDTH);
    localparam logic [PW-1:0] PH_LAST = PW'(2*WIDTH-1);
    localparam logic [PW-1:0] PH_HALF = PW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_n;
    logic [WIDTH-1:0]    out_n;
    logic [PW-1:0]       phase_n;
    logic                dir_r, dir_n;
    logic [STEPS_W-1:0]  rem, rem_n;
    logic [PERIOD_W-1:0] pcnt, pcnt_n, period_reg, period_n;
    logic                ab_r, ab_n;

    // Handshake/status outputs are pure decodes of the state register.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign aborted   = (state == DONE) && ab_r;

    // State and datapath registers; reset overrides any in-flight command.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state      <= IDLE;
            out        <= '0;
            phase      <= '0;
            dir_r      <= 1'b0;
            rem        <= '0;
            pcnt       <= '0;
            period_reg <= '0;
            ab_r       <= 1'b0;
        end else begin
            state      <= state_n;
            out        <= out_n;
            phase      <= phase_n;
            dir_r      <= dir_n;
            rem        <= rem_n;
            pcnt       <= pcnt_n;
            period_reg <= period_n;
            ab_r       <= ab_n;
        end
    end

    // Next-state logic: command accept, home path choice, prescaled stepping.
    always_comb begin
        state_n  = state;
        out_n    = out;
        phase_n  = phase;
        dir_n    = dir_r;
        rem_n    = rem;
        pcnt_n   = pcnt;
        period_n = period_reg;
        ab_n     = ab_r;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    dir_n    = cmd_dir;
                    period_n = cmd_period;
                    pcnt_n   = cmd_period;
                    ab_n     = 1'b0;
                    if (cmd_home) begin
                        // Shortest way back to phase 0; the tie at WIDTH goes forward.
                        if (phase == '0) begin
                            rem_n = '0;
                        end else if (phase < PH_HALF) begin
                            dir_n = 1'b0;
                            rem_n = STEPS_W'(phase);
                        end else begin
                            dir_n = 1'b1;
                            rem_n = STEPS_W'(2*WIDTH) - STEPS_W'(phase);
                        end
                    end else begin
                        rem_n = cmd_steps;
                    end
                    state_n = (rem_n == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort wins over a due step.
                    ab_n    = 1'b1;
                    state_n = DONE;
                end else if (pcnt == '0) begin
                    if (dir_r) begin
                        out_n   = {out[WIDTH-2:0], ~out[WIDTH-1]};
                        phase_n = (phase == PH_LAST) ? '0 : phase + 1'b1;
                    end else begin
                        out_n   = {~out[0], out[WIDTH-1:1]};
                        phase_n = (phase == '0) ? PH_LAST : phase - 1'b1;
                    end
                    rem_n  = rem - 1'b1;
                    pcnt_n = period_reg;
                    if (rem == STEPS_W'(1)) state_n = DONE;
                end else begin
                    pcnt_n = pcnt - 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_johnson_step_sequencer.sv
// Directed bench for johnson_step_sequencer (WIDTH=4) with hand-computed expectations.
module tb_johnson_step_sequencer;
    logic       clk = 1'b0;
    logic       sync_reset, cmd_valid, cmd_ready, cmd_dir, cmd_home, abort;
    logic [7:0] cmd_steps, cmd_period;
    logic [3:0] out;
    logic [2:0] phase;
    logic       busy, done, aborted;

    int checks = 0;
    int errors = 0;
    int n;
    logic [3:0] fwd_seq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};

    johnson_step_sequencer #(.WIDTH(4), .STEPS_W(8), .PERIOD_W(8)) dut (
        .clk(clk), .sync_reset(sync_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_home(cmd_home), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .abort(abort), .out(out), .phase(phase), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command; returns just after the accept edge.
    task automatic send(input logic dir, input logic home, input int steps, input int period);
        for (int i = 0; i < 50 && !cmd_ready; i++) tick();
        cmd_valid = 1'b1; cmd_dir = dir; cmd_home = home;
        cmd_steps = 8'(steps); cmd_period = 8'(period);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Cycles from the accept edge to the done cycle, bounded.
    task automatic wait_done(input int maxc, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!done && cnt < maxc);
    endtask

    initial begin
        sync_reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_home = 1'b0;
        cmd_steps = '0; cmd_period = '0; abort = 1'b0;
        tick(); tick();
        sync_reset = 1'b0;
        chk("rst_out", out, 0);   chk("rst_phase", phase, 0);
        chk("rst_ready", cmd_ready, 1); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_abt", aborted, 0);

        // Forward 8 steps, period 0: one step per clock.
        send(1, 0, 8, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("fwd_out%0d", k), out, fwd_seq[k]);
            chk($sformatf("fwd_ph%0d", k), phase, (k + 1) % 8);
            chk($sformatf("fwd_done%0d", k), done, (k == 7));
        end
        chk("fwd_abt", aborted, 0);

        // Reverse 3 steps, period 2: steps at cycles 3, 6, 9.
        send(0, 0, 3, 2);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 2) chk("rev_hold", out, 4'b0000);
            if (k == 3) chk("rev_s1", out, 4'b1000);
            if (k == 6) chk("rev_s2", out, 4'b1100);
            if (k == 8) chk("rev_nodone", done, 0);
        end
        chk("rev_done", done, 1); chk("rev_out", out, 4'b1110); chk("rev_ph", phase, 5);

        // Home from 5: forward 3.
        send(1, 1, 0, 0);
        wait_done(50, n);
        chk("home5_lat", n, 3); chk("home5_out", out, 0); chk("home5_ph", phase, 0);

        // Home from 3: reverse 3, first step 0011.
        send(1, 0, 3, 0); wait_done(50, n);
        chk("f3_ph", phase, 3);
        send(1, 1, 0, 0);
        tick();
        chk("home3_s1", out, 4'b0011);
        wait_done(50, n);
        chk("home3_lat", n, 2); chk("home3_out", out, 0);

        // Home from 4: tie goes forward, first step 1110.
        send(1, 0, 4, 0); wait_done(50, n);
        chk("f4_out", out, 4'b1111);
        send(0, 1, 0, 0);
        tick();
        chk("home4_s1", out, 4'b1110);
        wait_done(50, n);
        chk("home4_lat", n, 3); chk("home4_out", out, 0); chk("home4_ph", phase, 0);

        // Home at phase 0: done one cycle after accept, no step.
        send(0, 1, 0, 0);
        chk("home0_done", done, 1); chk("home0_out", out, 0);

        // Abort on the cycle the 5th step is due (steps at 2,4,6,8; due at 10).
        send(1, 0, 10, 1);
        for (int k = 1; k <= 9; k++) tick();
        chk("ab_pre_out", out, 4'b1111);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_done", done, 1); chk("ab_abt", aborted, 1);
        chk("ab_out", out, 4'b1111); chk("ab_ph", phase, 4);
        tick();
        chk("ab_idle", cmd_ready, 1); chk("ab_abt_clr", aborted, 0);

        // cmd_valid held: forward 2 then a zero-step command.
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_home = 1'b0; cmd_steps = 8'd2; cmd_period = 8'd0;
        tick();
        chk("hold_busy", busy, 1); chk("hold_rdy_run", cmd_ready, 0);
        cmd_steps = 8'd0;
        tick();
        chk("hold_rdy_run2", cmd_ready, 0);
        tick();
        chk("hold_done", done, 1); chk("hold_rdy_done", cmd_ready, 0); chk("hold_ph", phase, 6);
        tick();
        chk("hold_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("zero_done", done, 1); chk("zero_abt", aborted, 0);
        chk("zero_out", out, 4'b1100); chk("zero_ph", phase, 6);
        tick();
        chk("zero_end", done, 0);

        // Reset mid-run at phase 6.
        sync_reset = 1'b1; tick(); sync_reset = 1'b0;
        send(1, 0, 8, 0);
        for (int k = 0; k < 6; k++) tick();
        chk("mid_ph", phase, 6); chk("mid_busy", busy, 1);
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        chk("mr_out", out, 0); chk("mr_ph", phase, 0); chk("mr_rdy", cmd_ready, 1);
        chk("mr_busy", busy, 0); chk("mr_done", done, 0);
        for (int k = 0; k < 10; k++) tick();
        chk("mr_still_out", out, 0); chk("mr_still_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/johnson_step_sequencer.md
Name: johnson_step_sequencer

Overview:
- Command-driven controller for a 2*WIDTH-state Johnson ring.
- Owns the Johnson register and advances it forward or backward by a requested number of steps, one step every cmd_period+1 clocks.
- Also supports a "home" command that returns the ring to all-zeros by the shortest path.
- Sits between a command source (valid/ready) and phase-driven logic such as stepper drive or multi-phase enables.

Parameters:
- WIDTH, 4: Johnson stages; ring has 2*WIDTH states.
- STEPS_W, 8: width of the step count.
- PERIOD_W, 8: width of the step-period prescaler.

Ports:
- clk  input  1  system clock, rising edge.
- sync_reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_dir  input  1  1 = forward, 0 = reverse; ignored when cmd_home=1.
- cmd_home  input  1  return to phase 0 by the shortest path; cmd_steps ignored.
- cmd_steps  input  STEPS_W  number of steps to take.
- cmd_period  input  PERIOD_W  clocks between steps, minus 1.
- abort  input  1  terminate the running command.
- out  output  WIDTH  Johnson pattern (registered).
- phase  output  clog2(2*WIDTH)  index of the current pattern, 0..2*WIDTH-1.
- busy  output  1  command in progress (RUN state).
- done  output  1  one-cycle completion pulse.
- aborted  output  1  qualifies done: 1 = the command was aborted; 0 when done=0.

Behaviour:
- Reset (sync_reset high at a clk edge): out=0, phase=0, state=IDLE, cmd_ready=1, busy=0, done=0, aborted=0. Reset overrides everything, including an in-flight command.
- Forward step: out <= {out[WIDTH-2:0], ~out[WIDTH-1]}; phase <= (phase+1) mod 2*WIDTH.
  - WIDTH=4 sequence from 0000: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
- Reverse step: out <= {~out[0], out[WIDTH-1:1]}; phase <= (phase-1) mod 2*WIDTH.
- phase always equals the index of out within the forward sequence starting at 0.
- out changes only on a step or on reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1; accept when cmd_valid && cmd_ready.
  - On accept, latch: dir, period_reg = cmd_period, pcnt = cmd_period.
  - rem for a normal command = cmd_steps.
  - For a home command, with p = phase:
    - p=0: rem=0.
    - 0<p<WIDTH: reverse, rem=p.
    - p>=WIDTH: forward, rem=2*WIDTH-p. The tie at p=WIDTH goes forward.
  - If rem==0 -> DONE; else -> RUN.
- RUN (busy=1, cmd_ready=0), evaluated each cycle in priority order:
  - abort -> DONE with aborted=1; no step this cycle, even if pcnt==0.
  - else if pcnt==0 -> take one step, rem<=rem-1, pcnt<=period_reg; if rem==1 -> DONE.
  - else pcnt<=pcnt-1.
- DONE:
  - Lasts exactly one cycle; done=1, aborted per cause, cmd_ready=0, busy=0. Then -> IDLE.
  - out already shows the final pattern during this cycle.
- Timing:
  - First step lands cmd_period+1 edges after the accept edge; later steps are spaced cmd_period+1 clocks apart.
  - With cmd_period=0, out changes every clock.
  - done rises on the same edge as the last step.
  - Total accept-to-done latency = cmd_steps*(cmd_period+1) clocks.
- Command handling:
  - cmd_steps=0 (non-home) gives done one cycle after accept, aborted=0, with no step.
  - Commands presented while not in IDLE are not accepted; cmd_valid must be held by the source.
  - abort in IDLE or DONE is ignored.
- Widths: rem is STEPS_W bits and pcnt is PERIOD_W bits; neither wraps (decrement only at non-zero).
- Home rem is at most WIDTH and must fit in STEPS_W (require 2*WIDTH <= 2^STEPS_W).

Test Plan:
- Reset, then forward cmd_steps=8, cmd_period=0 -> out walks 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 on consecutive clocks. phase goes 1..7, 0. done pulses with the last step, aborted=0. Latency 8 clocks.
- From 0000, reverse cmd_steps=3, cmd_period=2 -> out 1000, 1100, 1110, stepping every 3 clocks. phase ends at 5. done at clock 9 after accept.
- Forward 5 steps, then home -> phase 5 -> forward 3 steps to 0000. Then forward 3 steps, then home -> phase 3 -> reverse 3 steps to 0000. Then forward 4 steps, then home -> tie at phase 4 -> forward 4 steps.
- cmd_steps=10, period=1, abort asserted on the cycle a step is due after 4 steps -> no 5th step. done=1 with aborted=1 the next cycle. out=1111, phase=4.
- cmd_valid held high throughout a run -> cmd_ready stays 0 during RUN and DONE. Second command accepted in the first IDLE cycle. cmd_steps=0 -> done one cycle after accept, out unchanged.
- sync_reset asserted mid-RUN at phase 6 -> next cycle out=0, phase=0, cmd_ready=1, busy=0, done=0, and no further steps.
